fetch_unit: RTL

Instruction fetch front end for the RISC-V core. It is the producer side of the instruction/redirect interface of the main decoder/controller.
- It owns the PC and issues in-order requests to instruction memory over a valid/ready request channel.
- It buffers returned words in a small queue and presents {Instr, PC, PCPlus4} to decode with a valid/ready handshake.
- It consumes the controller's PCSrc/PCTarget redirect and flushes wrong-path work.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit_sync_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 102 ++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the core front end.
//   XLEN             - architectural register / address width
//   RESET_PC_DEFAULT - default first fetch address after reset
//   fetch_entry_t    - one instruction-queue entry {instr, pc}
`timescale 1ns/1ps
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle between the fetch unit, instruction memory and
// decode.
//   imem_req_*  - request channel, fetch unit -> memory
//   imem_resp_* - response channel, memory -> fetch unit (no backpressure)
//   instr_*, Instr, PC, PCPlus4 - instruction channel, fetch unit -> decode
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where valid and ready are both 1. valid never depends on ready
// of the same channel, and data is only meaningful while valid is 1.
`timescale 1ns/1ps
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;

  // fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    output instr_valid, Instr, PC, PCPlus4,
    input  instr_ready
  );

  // memory + decode side
  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    input  instr_valid, Instr, PC, PCPlus4,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush and occupancy count.
//   clk, rst      - clock, synchronous active-high reset
//   flush         - empty the FIFO this cycle (wins over push/pop)
//   push, wdata   - write one entry
//   pop           - discard the head entry (ignored when empty)
//   rdata         - head entry, read straight from the storage registers
//   count         - number of valid entries
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full;
  logic             do_pop;
  logic             do_push;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && (cnt != '0);
  // A push into a full FIFO is only accepted when the head leaves together.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;

  // Callers size their credits so an unmatched push never meets a full FIFO.
  overflow_check: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   clk, reset         - clock, synchronous active-high reset
//   PCSrc, PCTarget    - redirect strobe and target from the controller
//   bus (master)       - imem request/response and decode instruction channel
// Owns the fetch PC, issues in-order word fetches under a credit limit,
// queues returned words with their addresses and drops wrong-path responses
// after a redirect.
`timescale 1ns/1ps
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2,
  parameter int          MAXOUT   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc,
  input  logic [31:0]  PCTarget,
  fetch_unit_if.master bus
);
  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int OCW = $clog2(MAXOUT + 1);

  logic [31:0]         fetch_pc;
  logic [OCW-1:0]      drop_cnt;
  logic [OCW-1:0]      outstanding;
  logic [QCW-1:0]      q_count;
  logic [31:0]         addr_head;
  logic [$bits(fetch_entry_t)-1:0] head_bits;
  fetch_entry_t        head;
  fetch_entry_t        entry_in;
  logic                req_valid;
  logic                req_fire;
  logic                resp;
  logic                q_push;
  logic                q_pop;
  logic                head_valid;

  // Credits count both queued and in-flight words so every response has a
  // queue slot waiting for it.
  assign req_valid = !reset && !PCSrc
                  && ((int'(q_count) + int'(outstanding)) < QDEPTH)
                  && (int'(outstanding) < MAXOUT);
  assign req_fire  = req_valid && bus.imem_req_ready;
  assign resp      = bus.imem_resp_valid;

  // Responses during a redirect, or still owed to the old path, are dropped.
  assign q_push   = resp && !PCSrc && (drop_cnt == '0);
  assign q_pop    = head_valid && bus.instr_ready && !PCSrc;
  assign entry_in = '{instr: bus.imem_resp_data, pc: addr_head};

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (PCSrc) begin
      fetch_pc <= {PCTarget[31:2], 2'b00};
      // Recomputed from outstanding, so back-to-back redirects accumulate.
      drop_cnt <= outstanding - OCW'(resp);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - OCW'(1);
    end
  end

  // Issued addresses in flight; its occupancy is the outstanding count.
  // Not flushed on redirect: dropped responses pop their address too, which
  // keeps it aligned with the memory's response order.
  sync_fifo #(.WIDTH(32), .DEPTH(MAXOUT)) u_addr_fifo (
    .clk   (clk),
    .rst   (reset),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (resp),
    .rdata (addr_head),
    .count (outstanding)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .rst   (reset),
    .flush (PCSrc),
    .push  (q_push),
    .wdata (entry_in),
    .pop   (q_pop),
    .rdata (head_bits),
    .count (q_count)
  );

  assign head       = fetch_entry_t'(head_bits);
  assign head_valid = (q_count != '0);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = head_valid;
  // Outputs read zero when the queue is empty, e.g. straight out of reset.
  assign bus.Instr          = head_valid ? head.instr : '0;
  assign bus.PC             = head_valid ? head.pc : '0;
  assign bus.PCPlus4        = head_valid ? head.pc + 32'd4 : '0;
endmodule
